// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: configuration sequencer for a bank of pwm channels.
// Each channel holds a target duty (tgt) and an applied duty (cur). cur either
// jumps to the written value on an immediate write, or slews one step toward
// tgt on every prescaler tick. Any change to cur marks the channel pending.
// A round-robin arbiter then sends one pending channel per cycle to the pwm
// bank, as a one-hot cs strobe plus its duty on the shared uptime bus.
module pwm_ramp_ctrl #(
    parameter int NCH      = 4,
    parameter int DW       = 3,
    parameter int RAMP_DIV = 8,
    parameter int AW       = 2
) (
    input  logic           clkin,
    input  logic           reset,
    input  logic           wr_en,
    input  logic [AW-1:0]  wr_addr,
    input  logic [DW-1:0]  wr_data,
    input  logic           wr_imm,
    output logic [NCH-1:0] cs,
    output logic [DW-1:0]  uptime,
    output logic           busy
);

    // Index width for the arbiter pointer, plus one spare bit so that the
    // modulo-NCH search can be done with a single conditional subtract.
    localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW = SW + 1;
    localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    localparam logic [PW-1:0] PS_LAST = PW'(RAMP_DIV - 1);
    localparam logic [SW-1:0] RR_INIT = SW'(NCH - 1);
    localparam logic [CW-1:0] NCH_CW  = CW'(NCH);

    // ------------------------------------------------------------------
    // Ramp prescaler
    // ------------------------------------------------------------------
    logic [PW-1:0] ps_reg;
    logic          tick;

    // With RAMP_DIV=1 the counter sits at 0, which equals PS_LAST, so tick
    // is high on every cycle.
    assign tick = (ps_reg == PS_LAST);

    // Free-running count 0..RAMP_DIV-1, wrapping on tick.
    always_ff @(posedge clkin) begin
        if (reset) begin
            ps_reg <= '0;
        end else if (tick) begin
            ps_reg <= '0;
        end else begin
            ps_reg <= ps_reg + PW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Per-channel state
    // ------------------------------------------------------------------
    logic [NCH-1:0][DW-1:0] cur_vec;
    logic [NCH-1:0]         pend_vec;
    logic [NCH-1:0]         ramp_vec;
    logic [NCH-1:0]         grant_vec;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [DW-1:0] tgt_reg;
            logic [DW-1:0] cur_reg;
            logic          pend_reg;
            logic          wr_hit;
            logic          imm_hit;
            logic          step_en;

            // Addresses at or above NCH match no channel and are dropped.
            assign wr_hit  = wr_en && (wr_addr == AW'(gi));
            assign imm_hit = wr_hit && wr_imm;
            // The step decision uses the registered tgt, so a ramp write
            // landing on a tick only takes effect from the next tick.
            assign step_en = tick && (cur_reg != tgt_reg);

            // Target/applied duty update: immediate write beats the ramp
            // step; a channel whose cur changes becomes pending, and a new
            // change outranks the arbiter clearing it in the same cycle.
            always_ff @(posedge clkin) begin
                if (reset) begin
                    tgt_reg  <= '0;
                    cur_reg  <= '0;
                    pend_reg <= 1'b0;
                end else begin
                    if (wr_hit) begin
                        tgt_reg <= wr_data;
                    end

                    if (imm_hit) begin
                        cur_reg <= wr_data;
                    end else if (step_en) begin
                        if (tgt_reg > cur_reg) begin
                            cur_reg <= cur_reg + DW'(1);
                        end else begin
                            cur_reg <= cur_reg - DW'(1);
                        end
                    end

                    if (imm_hit || step_en) begin
                        pend_reg <= 1'b1;
                    end else if (grant_vec[gi]) begin
                        pend_reg <= 1'b0;
                    end
                end
            end

            assign cur_vec[gi]  = cur_reg;
            assign pend_vec[gi] = pend_reg;
            assign ramp_vec[gi] = (cur_reg != tgt_reg);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin arbiter
    // ------------------------------------------------------------------
    logic [SW-1:0] rr_reg;
    logic [SW-1:0] sel;
    logic          any_pend;
    logic [CW-1:0] cand;

    // Search rr+1, rr+2, ... (mod NCH) and take the first pending channel;
    // the last channel served therefore has the lowest priority next time.
    always_comb begin
        sel      = rr_reg;
        any_pend = 1'b0;
        cand     = '0;
        for (int k = 1; k <= NCH; k++) begin
            cand = {1'b0, rr_reg} + CW'(k);
            if (cand >= NCH_CW) begin
                cand = cand - NCH_CW;
            end
            if (!any_pend && pend_vec[cand[SW-1:0]]) begin
                any_pend = 1'b1;
                sel      = cand[SW-1:0];
            end
        end
    end

    assign grant_vec = any_pend ? (NCH'(1) << sel) : '0;

    // ------------------------------------------------------------------
    // Registered outputs to the pwm bank
    // ------------------------------------------------------------------
    logic [NCH-1:0] cs_reg;
    logic [DW-1:0]  uptime_reg;

    // Issue one cs pulse per cycle; uptime keeps the last sent duty when
    // no channel is being loaded.
    always_ff @(posedge clkin) begin
        if (reset) begin
            cs_reg     <= '0;
            uptime_reg <= '0;
            rr_reg     <= RR_INIT;
        end else begin
            cs_reg <= grant_vec;
            if (any_pend) begin
                uptime_reg <= cur_vec[sel];
                rr_reg     <= sel;
            end
        end
    end

    assign cs     = cs_reg;
    assign uptime = uptime_reg;
    assign busy   = (|pend_vec) || (|ramp_vec) || (|cs_reg);

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed testbench for pwm_ramp_ctrl. Two instances: the default build
// (4 channels, RAMP_DIV=8) and a 3-channel build with RAMP_DIV=1 so that an
// out-of-range address exists. Outputs are logged once per cycle on the
// falling edge, indexed by the number of rising edges since the last reset.
module tb_pwm_ramp_ctrl;

    logic       clkin = 1'b0;
    logic       reset;

    logic       wr_en, wr_imm;
    logic [1:0] wr_addr;
    logic [2:0] wr_data;
    logic [3:0] cs;
    logic [2:0] uptime;
    logic       busy;

    logic       wr_en1, wr_imm1;
    logic [1:0] wr_addr1;
    logic [2:0] wr_data1;
    logic [2:0] cs1;
    logic [2:0] uptime1;
    logic       busy1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [3:0] cs_log    [0:255];
    logic [2:0] up_log    [0:255];
    logic       busy_log  [0:255];
    logic [2:0] cs1_log   [0:255];
    logic [2:0] up1_log   [0:255];
    logic       busy1_log [0:255];

    always #5 clkin = ~clkin;

    always @(posedge clkin) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    pwm_ramp_ctrl #(.NCH(4), .DW(3), .RAMP_DIV(8), .AW(2)) dut (
        .clkin   (clkin),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_imm  (wr_imm),
        .cs      (cs),
        .uptime  (uptime),
        .busy    (busy)
    );

    pwm_ramp_ctrl #(.NCH(3), .DW(3), .RAMP_DIV(1), .AW(2)) dut1 (
        .clkin   (clkin),
        .reset   (reset),
        .wr_en   (wr_en1),
        .wr_addr (wr_addr1),
        .wr_data (wr_data1),
        .wr_imm  (wr_imm1),
        .cs      (cs1),
        .uptime  (uptime1),
        .busy    (busy1)
    );

    // Advance one cycle, log both instances, and drop any one-cycle write.
    task automatic step();
        @(negedge clkin);
        if (cyc >= 0 && cyc < 256) begin
            cs_log[cyc]    = cs;
            up_log[cyc]    = uptime;
            busy_log[cyc]  = busy;
            cs1_log[cyc]   = cs1;
            up1_log[cyc]   = uptime1;
            busy1_log[cyc] = busy1;
        end
        wr_en  = 1'b0;
        wr_en1 = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic clear_logs();
        for (int c = 0; c < 256; c++) begin
            cs_log[c]    = 'x;
            up_log[c]    = 'x;
            busy_log[c]  = 1'bx;
            cs1_log[c]   = 'x;
            up1_log[c]   = 'x;
            busy1_log[c] = 1'bx;
        end
    endtask

    // Leaves the bench on the falling edge right after the reset edge (cyc 0).
    task automatic do_reset();
        clear_logs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic wr0(input logic [1:0] a, input logic [2:0] d, input logic imm);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_imm = imm;
        step();
    endtask

    task automatic wr1(input logic [1:0] a, input logic [2:0] d, input logic imm);
        wr_en1 = 1'b1; wr_addr1 = a; wr_data1 = d; wr_imm1 = imm;
        step();
    endtask

    function automatic int count0(input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) if (cs_log[c] !== 4'b0000) n++;
        return n;
    endfunction

    function automatic int count1(input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) if (cs1_log[c] !== 3'b000) n++;
        return n;
    endfunction

    // Reset values of both instances and quiet idle afterwards.
    task automatic test_reset();
        int n;
        clear_logs();
        reset = 1'b1;
        step();
        step();
        n_checks++;
        if (cs !== 4'b0000) begin n_fail++; $display("FAIL reset_cs: got %b expected 0000", cs); end
        n_checks++;
        if (uptime !== 3'd0) begin n_fail++; $display("FAIL reset_uptime: got %0d expected 0", uptime); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++;
        if (cs1 !== 3'b000 || uptime1 !== 3'd0 || busy1 !== 1'b0) begin
            n_fail++; $display("FAIL reset_dut1: got cs=%b up=%0d busy=%b expected 000/0/0", cs1, uptime1, busy1);
        end
        reset = 1'b0;
        run(20);
        n = count0(1, 20);
        n_checks++;
        if (n !== 0) begin n_fail++; $display("FAIL reset_idle_pulses: got %0d expected 0", n); end
        $display("test_reset done");
    endtask

    // ch0 ramps 0->5: ticks at edges 8,16,..; pulses one cycle later.
    task automatic test_ramp_up();
        int n;
        do_reset();
        wr0(2'd0, 3'd5, 1'b0);
        run(59);
        n = count0(1, 60);
        n_checks++;
        if (n !== 5) begin n_fail++; $display("FAIL ramp_up_count: got %0d expected 5", n); end
        for (int j = 0; j < 5; j++) begin
            int c = 9 + 8 * j;
            logic [2:0] exp_up = 3'(j + 1);
            n_checks++;
            if (cs_log[c] !== 4'b0001 || up_log[c] !== exp_up) begin
                n_fail++;
                $display("FAIL ramp_up_pulse%0d: got cs=%b up=%0d at cycle %0d, expected cs=0001 up=%0d", j, cs_log[c], up_log[c], c, exp_up);
            end
        end
        n_checks++;
        if (busy_log[5] !== 1'b1) begin n_fail++; $display("FAIL ramp_up_busy_ramping: got %b expected 1", busy_log[5]); end
        n_checks++;
        if (busy_log[41] !== 1'b1) begin n_fail++; $display("FAIL ramp_up_busy_last_pulse: got %b expected 1", busy_log[41]); end
        n_checks++;
        if (busy_log[42] !== 1'b0) begin n_fail++; $display("FAIL ramp_up_busy_done: got %b expected 0", busy_log[42]); end
        n_checks++;
        if (up_log[50] !== 3'd5) begin n_fail++; $display("FAIL ramp_up_uptime_hold: got %0d expected 5", up_log[50]); end
        $display("test_ramp_up done, pulses=%0d", n);
    endtask

    // Immediate write ch2=6 sampled at edge 1 -> single pulse at edge 2.
    task automatic test_immediate();
        int n;
        do_reset();
        wr0(2'd2, 3'd6, 1'b1);
        run(29);
        n_checks++;
        if (cs_log[1] !== 4'b0000) begin n_fail++; $display("FAIL imm_cs_early: got %b expected 0000", cs_log[1]); end
        n_checks++;
        if (cs_log[2] !== 4'b0100 || up_log[2] !== 3'd6) begin
            n_fail++; $display("FAIL imm_pulse: got cs=%b up=%0d expected cs=0100 up=6", cs_log[2], up_log[2]);
        end
        n_checks++;
        if (cs_log[3] !== 4'b0000 || up_log[3] !== 3'd6) begin
            n_fail++; $display("FAIL imm_after: got cs=%b up=%0d expected cs=0000 up=6", cs_log[3], up_log[3]);
        end
        n = count0(1, 30);
        n_checks++;
        if (n !== 1) begin n_fail++; $display("FAIL imm_count: got %0d expected 1", n); end
        n_checks++;
        if (busy_log[1] !== 1'b1) begin n_fail++; $display("FAIL imm_busy_pend: got %b expected 1", busy_log[1]); end
        n_checks++;
        if (busy_log[3] !== 1'b0) begin n_fail++; $display("FAIL imm_busy_done: got %b expected 0", busy_log[3]); end
        $display("test_immediate done, pulses=%0d", n);
    endtask

    // All four channels ramp 0->7 together; each tick yields ch0..ch3 in turn.
    task automatic test_round_robin();
        int n;
        do_reset();
        wr0(2'd0, 3'd7, 1'b0);
        wr0(2'd1, 3'd7, 1'b0);
        wr0(2'd2, 3'd7, 1'b0);
        wr0(2'd3, 3'd7, 1'b0);
        run(66);
        for (int r = 1; r <= 7; r++) begin
            for (int j = 0; j < 4; j++) begin
                int c = 8 * r + 1 + j;
                logic [3:0] exp_cs = 4'(1 << j);
                logic [2:0] exp_up = 3'(r);
                n_checks++;
                if (cs_log[c] !== exp_cs || up_log[c] !== exp_up) begin
                    n_fail++;
                    $display("FAIL rr_r%0d_ch%0d: got cs=%b up=%0d expected cs=%b up=%0d", r, j, cs_log[c], up_log[c], exp_cs, exp_up);
                end
            end
        end
        n = count0(1, 70);
        n_checks++;
        if (n !== 28) begin n_fail++; $display("FAIL rr_count: got %0d expected 28", n); end
        n_checks++;
        if (busy_log[60] !== 1'b1 || busy_log[61] !== 1'b0) begin
            n_fail++; $display("FAIL rr_busy_end: got %b%b expected 10", busy_log[60], busy_log[61]);
        end
        $display("test_round_robin done, pulses=%0d", n);
    endtask

    // ch1 set to 4, ramps down toward 1, then an immediate 7 lands on a tick.
    task automatic test_ramp_down_collision();
        int n;
        do_reset();
        wr0(2'd1, 3'd4, 1'b1);
        run(1);
        wr0(2'd1, 3'd1, 1'b0);
        run(20);
        wr0(2'd1, 3'd7, 1'b1);
        run(26);
        n_checks++;
        if (cs_log[2] !== 4'b0010 || up_log[2] !== 3'd4) begin
            n_fail++; $display("FAIL down_first: got cs=%b up=%0d expected cs=0010 up=4", cs_log[2], up_log[2]);
        end
        n_checks++;
        if (cs_log[9] !== 4'b0010 || up_log[9] !== 3'd3) begin
            n_fail++; $display("FAIL down_step3: got cs=%b up=%0d expected cs=0010 up=3", cs_log[9], up_log[9]);
        end
        n_checks++;
        if (cs_log[17] !== 4'b0010 || up_log[17] !== 3'd2) begin
            n_fail++; $display("FAIL down_step2: got cs=%b up=%0d expected cs=0010 up=2", cs_log[17], up_log[17]);
        end
        n_checks++;
        if (cs_log[25] !== 4'b0010 || up_log[25] !== 3'd7) begin
            n_fail++; $display("FAIL collision_imm: got cs=%b up=%0d expected cs=0010 up=7", cs_log[25], up_log[25]);
        end
        n = count0(1, 50);
        n_checks++;
        if (n !== 4) begin n_fail++; $display("FAIL collision_count: got %0d expected 4", n); end
        n_checks++;
        if (busy_log[26] !== 1'b0) begin n_fail++; $display("FAIL collision_busy: got %b expected 0", busy_log[26]); end
        $display("test_ramp_down_collision done, pulses=%0d", n);
    endtask

    // Reset while ch0 sits at cur=3 with its pulse about to go out.
    task automatic test_reset_mid_ramp();
        int n;
        do_reset();
        wr0(2'd0, 3'd7, 1'b0);
        run(23);
        n_checks++;
        if (cs_log[17] !== 4'b0001 || up_log[17] !== 3'd2) begin
            n_fail++; $display("FAIL midreset_pre: got cs=%b up=%0d expected cs=0001 up=2", cs_log[17], up_log[17]);
        end
        do_reset();
        n_checks++;
        if (cs_log[0] !== 4'b0000 || up_log[0] !== 3'd0 || busy_log[0] !== 1'b0) begin
            n_fail++; $display("FAIL midreset_after: got cs=%b up=%0d busy=%b expected 0000/0/0", cs_log[0], up_log[0], busy_log[0]);
        end
        run(40);
        n = count0(0, 40);
        n_checks++;
        if (n !== 0) begin n_fail++; $display("FAIL midreset_pulses: got %0d expected 0", n); end
        n_checks++;
        if (busy_log[10] !== 1'b0 || busy_log[40] !== 1'b0) begin
            n_fail++; $display("FAIL midreset_busy: got %b%b expected 00", busy_log[10], busy_log[40]);
        end
        $display("test_reset_mid_ramp done");
    endtask

    // 3-channel, RAMP_DIV=1 instance: invalid address, then 0->3 back to back.
    task automatic test_invalid_addr_div1();
        int n;
        do_reset();
        wr1(2'd3, 3'd5, 1'b1);
        run(9);
        n = count1(1, 10);
        n_checks++;
        if (n !== 0) begin n_fail++; $display("FAIL invalid_pulses: got %0d expected 0", n); end
        n_checks++;
        if (busy1_log[2] !== 1'b0 || busy1_log[10] !== 1'b0) begin
            n_fail++; $display("FAIL invalid_busy: got %b%b expected 00", busy1_log[2], busy1_log[10]);
        end
        wr1(2'd0, 3'd3, 1'b0);
        run(10);
        n_checks++;
        if (cs1_log[12] !== 3'b000) begin n_fail++; $display("FAIL div1_early: got %b expected 000", cs1_log[12]); end
        for (int j = 0; j < 3; j++) begin
            int c = 13 + j;
            logic [2:0] exp_up = 3'(j + 1);
            n_checks++;
            if (cs1_log[c] !== 3'b001 || up1_log[c] !== exp_up) begin
                n_fail++;
                $display("FAIL div1_pulse%0d: got cs=%b up=%0d expected cs=001 up=%0d", j, cs1_log[c], up1_log[c], exp_up);
            end
        end
        n_checks++;
        if (cs1_log[16] !== 3'b000 || busy1_log[16] !== 1'b0 || busy1_log[15] !== 1'b1) begin
            n_fail++; $display("FAIL div1_end: got cs=%b busy15=%b busy16=%b expected 000/1/0", cs1_log[16], busy1_log[15], busy1_log[16]);
        end
        n = count1(11, 21);
        n_checks++;
        if (n !== 3) begin n_fail++; $display("FAIL div1_count: got %0d expected 3", n); end
        $display("test_invalid_addr_div1 done, pulses=%0d", n);
    endtask

    initial begin
        reset    = 1'b1;
        wr_en    = 1'b0; wr_imm  = 1'b0; wr_addr  = '0; wr_data  = '0;
        wr_en1   = 1'b0; wr_imm1 = 1'b0; wr_addr1 = '0; wr_data1 = '0;
        test_reset();
        test_ramp_up();
        test_immediate();
        test_round_robin();
        test_ramp_down_collision();
        test_reset_mid_ramp();
        test_invalid_addr_div1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
